display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_if.sv | 13 +
 rtl/display_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Write port of the display scan controller: valid/ready transfer of one
// digit pattern into the shadow buffer.
interface display_scan_if #(
  parameter int unsigned WIDTH = 15
);
  logic             wr_valid;
  logic             wr_ready;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed display scanner with shadow/active buffers, guard blanking
// and PWM brightness. Optional per-digit masking when DIGIT_MASK_EN is defined.
module display_scan_ctrl #(
  parameter int unsigned WIDTH        = 15,
  parameter int unsigned DWELL_BITS   = 13,
  parameter int unsigned BRIGHT_BITS  = 3,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  display_scan_if.slave          wr,
  input  logic [BRIGHT_BITS-1:0] brightness,
`ifdef DIGIT_MASK_EN
  input  logic [3:0]             digit_mask,
`endif
  output logic [3:0]             columns,
  output logic [WIDTH-1:0]       outputdata,
  output logic                   frame_tick
);

  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COMMIT, SCAN, GUARD} state_t;

  state_t                state, state_next;
  logic [DWELL_BITS-1:0] dwell_cnt;
  logic [GW-1:0]         guard_cnt;
  logic [1:0]            digit;
  logic [WIDTH-1:0]      shadow [4];
  logic [WIDTH-1:0]      active [4];
  logic                  dwell_last, guard_last, next_digit, lit, blanked;
  logic [3:0]            columns_d;
  logic [WIDTH-1:0]      data_d;

  assign dwell_last = (dwell_cnt == '1);
  assign guard_last = (guard_cnt == GW'(GUARD_CYCLES - 1));
  assign next_digit = (state == GUARD) && guard_last && enable && (digit != 2'd3);
  assign lit        = (dwell_cnt[DWELL_BITS-1 -: BRIGHT_BITS] <= brightness);

`ifdef DIGIT_MASK_EN
  logic [3:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                mask <= '0;
    else if (state == COMMIT)  mask <= digit_mask;
  end

  assign blanked = mask[digit];
`else
  assign blanked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (enable) state_next = COMMIT;
      COMMIT: state_next = SCAN;
      SCAN:   if (dwell_last) state_next = GUARD;
      GUARD:
        if (guard_last) begin
          if (!enable)            state_next = IDLE;
          else if (digit == 2'd3) state_next = COMMIT;
          else                    state_next = SCAN;
        end
      default: state_next = IDLE;
    endcase
  end

  // columns_d/data_d are next-cycle values; the output registers add one cycle.
  always_comb begin
    wr.wr_ready = (state != COMMIT);
    frame_tick  = (state == COMMIT);
    columns_d   = '0;
    data_d      = '0;
    if (state == SCAN && lit && !blanked) begin
      columns_d = 4'b0001 << digit;
      data_d    = active[digit];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      guard_cnt <= '0;
      digit     <= '0;
    end else begin
      if (state == SCAN) dwell_cnt <= dwell_cnt + 1'b1;
      else if (state == COMMIT || next_digit) dwell_cnt <= '0;

      if (state == SCAN && dwell_last) guard_cnt <= '0;
      else if (state == GUARD)         guard_cnt <= guard_cnt + 1'b1;

      if (state == COMMIT)  digit <= '0;
      else if (next_digit)  digit <= digit + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr.wr_valid && wr.wr_ready) shadow[wr.wr_addr] <= wr.wr_data;
      if (state == COMMIT)
        for (int unsigned i = 0; i < 4; i++) active[i] <= shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      columns    <= '0;
      outputdata <= '0;
    end else begin
      columns    <= columns_d;
      outputdata <= data_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed, table-driven bench for display_scan_ctrl (DWELL_BITS=4,
// BRIGHT_BITS=2, GUARD_CYCLES=2, frame = 73 cycles).
module tb_display_scan_ctrl;

  localparam int unsigned WIDTH = 15;

  typedef struct {
    int unsigned      off;
    logic [3:0]       cols;
    logic [WIDTH-1:0] data;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [1:0]       brightness;
  logic [3:0]       columns;
  logic [WIDTH-1:0] outputdata;
  logic             frame_tick;
`ifdef DIGIT_MASK_EN
  logic [3:0]       digit_mask = 4'b0000;
`endif

  display_scan_if #(.WIDTH(WIDTH)) bus ();

  display_scan_ctrl #(
    .WIDTH(WIDTH), .DWELL_BITS(4), .BRIGHT_BITS(2), .GUARD_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(bus.slave),
    .brightness(brightness),
`ifdef DIGIT_MASK_EN
    .digit_mask(digit_mask),
`endif
    .columns(columns), .outputdata(outputdata), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cur_off = 0;
  vec_t        vecs [34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv(input int unsigned target);
    while (cur_off < target) begin
      @(negedge clk);
      cur_off++;
    end
  endtask

  task automatic wait_tick(output int unsigned period);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 300);
    if (frame_tick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout actual=%0d cycles required=frame_tick", n);
    end
    period  = cur_off + n;
    cur_off = 0;
  endtask

  task automatic run_table(input int unsigned base, input int unsigned n);
    for (int unsigned i = base; i < base + n; i++) begin
      adv(vecs[i].off);
      chk($sformatf("vec%0d_cols", i), 32'(columns), 32'(vecs[i].cols));
      chk($sformatf("vec%0d_data", i), 32'(outputdata), 32'(vecs[i].data));
    end
  endtask

  task automatic set_vec(input int unsigned i, input int unsigned off,
                         input logic [3:0] c, input logic [WIDTH-1:0] d);
    vecs[i] = '{off: off, cols: c, data: d};
  endtask

  initial begin
    int unsigned p;
    int unsigned bad;

    // full brightness, loaded patterns: entries 0..10
    set_vec(0, 1, 4'h0, 15'h0);     set_vec(1, 2, 4'h1, 15'h1111);
    set_vec(2, 17, 4'h1, 15'h1111); set_vec(3, 18, 4'h0, 15'h0);
    set_vec(4, 20, 4'h2, 15'h2222); set_vec(5, 35, 4'h2, 15'h2222);
    set_vec(6, 38, 4'h4, 15'h3333); set_vec(7, 53, 4'h4, 15'h3333);
    set_vec(8, 56, 4'h8, 15'h4444); set_vec(9, 71, 4'h8, 15'h4444);
    set_vec(10, 72, 4'h0, 15'h0);
    // same frame with empty buffers: entries 11..21
    for (int unsigned i = 0; i < 11; i++) set_vec(11 + i, vecs[i].off, vecs[i].cols, 15'h0);
    // brightness=1: lit for first 8 cycles of each dwell: entries 22..33
    set_vec(22, 2, 4'h1, 15'h1111);  set_vec(23, 9, 4'h1, 15'h1111);
    set_vec(24, 10, 4'h0, 15'h0);    set_vec(25, 17, 4'h0, 15'h0);
    set_vec(26, 20, 4'h2, 15'h2222); set_vec(27, 27, 4'h2, 15'h2222);
    set_vec(28, 28, 4'h0, 15'h0);    set_vec(29, 38, 4'h4, 15'h3333);
    set_vec(30, 46, 4'h0, 15'h0);    set_vec(31, 56, 4'h8, 15'h4444);
    set_vec(32, 63, 4'h8, 15'h4444); set_vec(33, 64, 4'h0, 15'h0);

    rst_n = 1'b0; enable = 1'b0; brightness = 2'd3;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_columns", 32'(columns), 32'h0);
    chk("rst_data", 32'(outputdata), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_ready", 32'(bus.wr_ready), 32'h1);

    // enable with empty buffers
    enable = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("first_tick", 32'(frame_tick), 32'h1);
    chk("commit_ready", 32'(bus.wr_ready), 32'h0);
    cur_off = 0;
    run_table(11, 11);
    wait_tick(p);
    chk("frame_len", p, 32'd73);

    // reload in IDLE
    rst_n = 1'b0; enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 2'(i); bus.wr_data = 15'(32'h1111 * (i + 1));
      chk($sformatf("idle_ready%0d", i), 32'(bus.wr_ready), 32'h1);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    chk("idle_no_tick", 32'(frame_tick), 32'h0);
    enable = 1'b1;
    wait_tick(p);
    run_table(0, 11);

    brightness = 2'd1;
    wait_tick(p);
    chk("frame_len_dim", p, 32'd73);
    run_table(22, 12);
    brightness = 2'd3;

    // mid-frame writes to addr 2, last one wins at next commit
    wait_tick(p);
    adv(5);
    bus.wr_valid = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 15'h0123;
    chk("mid_ready", 32'(bus.wr_ready), 32'h1);
    adv(6);
    bus.wr_data = 15'h7FFF;
    adv(7);
    bus.wr_valid = 1'b0;
    adv(38);
    chk("old_d2_cols", 32'(columns), 32'h4);
    chk("old_d2_data", 32'(outputdata), 32'h3333);
    adv(50);
    chk("scan_ready", 32'(bus.wr_ready), 32'h1);
    wait_tick(p);
    chk("tick_ready", 32'(bus.wr_ready), 32'h0);
    adv(38);
    chk("new_d2_data", 32'(outputdata), 32'h7FFF);

    // drop enable during digit 1
    wait_tick(p);
    adv(25);
    enable = 1'b0;
    adv(35);
    chk("d1_last_cols", 32'(columns), 32'h2);
    adv(36);
    chk("d1_guard_cols", 32'(columns), 32'h0);
    bad = 0;
    for (int unsigned k = 37; k <= 200; k++) begin
      adv(k);
      if (columns !== 4'h0 || outputdata !== '0 || frame_tick !== 1'b0) bad++;
    end
    chk("disabled_dark", bad, 32'd0);
    enable = 1'b1;
    adv(201);
    chk("reenable_tick", 32'(frame_tick), 32'h1);
    cur_off = 0;
    adv(2);
    chk("reenable_d0_cols", 32'(columns), 32'h1);
    chk("reenable_d0_data", 32'(outputdata), 32'h1111);

    // asynchronous reset mid-scan
    adv(10);
    chk("pre_rst_cols", 32'(columns), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cols", 32'(columns), 32'h0);
    chk("async_rst_data", 32'(outputdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tick", 32'(frame_tick), 32'h1);
    cur_off = 0;
    adv(2);
    chk("post_rst_d0_cols", 32'(columns), 32'h1);
    chk("post_rst_d0_data", 32'(outputdata), 32'h0);
    adv(20);
    chk("post_rst_d1_data", 32'(outputdata), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
